cpu_bus_responder: RTL

- Memory-side responder on the CPU common data bus. It services CPU read requests (op = 2'b01) and returns one 512-bit line on common_data_bus with a one-cycle instr_write_en or mem_write_en strobe.
- Fetches lines from host memory through the DMA read port.
- Keeps one last-line buffer per address space (instruction, data), so a repeated request to the same line is answered without a DMA round trip.
- Sits between the CPU and the DMA read engine.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/line_buffer.sv | 52 +++++
 rtl/cpu_bus_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU bus responder.
// Ops, responder states and line-geometry defaults.
package bus_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_e;

  localparam int DEF_ADDRW     = 32;
  localparam int DEF_INW       = 512;
  localparam int DEF_LINE_OFFW = 6;
  localparam int LINE_BYTES    = 1 << DEF_LINE_OFFW;
  localparam int DEF_TAGW      = DEF_ADDRW - DEF_LINE_OFFW;

endpackage

// File: rtl/line_buffer.sv
// Single-entry line buffer: tag, valid bit and one data line.
// Valid and tag reset; the data line does not.
module line_buffer #(
  parameter int TAGW = 26,
  parameter int INW  = 512
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [TAGW-1:0] wr_tag,
  input  logic [INW-1:0]  wr_data,
  input  logic            wr_valid,
  input  logic            inv,
  input  logic [TAGW-1:0] cmp_tag,
  output logic            hit,
  output logic [INW-1:0]  rd_data
);

  logic            valid_q, valid_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [INW-1:0]  data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv) valid_d = 1'b0;
    if (wr_en) begin
      valid_d = wr_valid;
      tag_d   = wr_tag;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign hit     = valid_q && (tag_q == cmp_tag);
  assign rd_data = data_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus read responder with one last-line buffer per space.
// Misses are filled through the DMA read port with a timeout.
module cpu_bus_responder
  import bus_pkg::*;
#(
  parameter int ADDRW     = DEF_ADDRW,
  parameter int INW       = DEF_INW,
  parameter int LINE_OFFW = DEF_LINE_OFFW,
  parameter int DMA_TMO   = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [ADDRW-1:0] mem_address,
  input  logic             inv,
  output logic             dma_rd_req,
  output logic [ADDRW-1:0] dma_rd_addr,
  input  logic             dma_ready,
  input  logic             rd_valid,
  input  logic [INW-1:0]   dma_rd_data,
  output logic [INW-1:0]   common_data_bus,
  output logic             instr_write_en,
  output logic             mem_write_en,
  output logic             busy,
  output logic             dma_err
);

  localparam int TAGW = ADDRW - LINE_OFFW;
  localparam int CW   = $clog2(DMA_TMO);
  localparam logic [CW-1:0] CNT_MAX = CW'(DMA_TMO - 1);

  state_e          state_q, state_d;
  logic            space_q, space_d;
  logic [TAGW-1:0] line_q, line_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_seen_q, inv_seen_d;
  logic            err_q, err_d;
  logic [INW-1:0]  bus_q, bus_d;

  logic [TAGW-1:0] req_tag;
  logic            req_space;
  logic            ib_hit, db_hit;
  logic [INW-1:0]  ib_data, db_data;
  logic            sel_hit;
  logic [INW-1:0]  sel_data;
  logic            buf_inv, fill, fill_valid;
  logic            unused_addr_bits;

  assign req_tag   = mem_address[ADDRW-1:LINE_OFFW];
  assign req_space = mem_address[ADDRW-1];
  assign unused_addr_bits = ^mem_address[LINE_OFFW-1:0];

  assign sel_hit  = req_space ? db_hit : ib_hit;
  assign sel_data = req_space ? db_data : ib_data;

  // Mid-fill invalidates are deferred to the fill's valid bit.
  assign buf_inv    = inv && (state_q inside {IDLE, RESP, DRAIN});
  assign fill       = (state_q == WAIT) && rd_valid;
  assign fill_valid = !(inv_seen_q || inv);

  line_buffer #(.TAGW(TAGW), .INW(INW)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fill && !space_q),
    .wr_tag  (line_q),
    .wr_data (dma_rd_data),
    .wr_valid(fill_valid),
    .inv     (buf_inv),
    .cmp_tag (req_tag),
    .hit     (ib_hit),
    .rd_data (ib_data)
  );

  line_buffer #(.TAGW(TAGW), .INW(INW)) u_dbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fill && space_q),
    .wr_tag  (line_q),
    .wr_data (dma_rd_data),
    .wr_valid(fill_valid),
    .inv     (buf_inv),
    .cmp_tag (req_tag),
    .hit     (db_hit),
    .rd_data (db_data)
  );

  always_comb begin
    state_d    = state_q;
    space_d    = space_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    inv_seen_d = inv_seen_q;
    err_d      = err_q;
    bus_d      = bus_q;
    unique case (state_q)
      IDLE: begin
        inv_seen_d = 1'b0;
        if (op == OP_READ) begin
          space_d = req_space;
          line_d  = req_tag;
          if (sel_hit && !inv) begin
            bus_d   = sel_data;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        inv_seen_d = inv_seen_q | inv;
        if (dma_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        inv_seen_d = inv_seen_q | inv;
        if (rd_valid) begin
          bus_d   = dma_rd_data;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        inv_seen_d = 1'b0;
        state_d    = DRAIN;
      end
      DRAIN: begin
        inv_seen_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      space_q    <= 1'b0;
      line_q     <= '0;
      cnt_q      <= '0;
      inv_seen_q <= 1'b0;
      err_q      <= 1'b0;
      bus_q      <= '0;
    end else begin
      state_q    <= state_d;
      space_q    <= space_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      inv_seen_q <= inv_seen_d;
      err_q      <= err_d;
      bus_q      <= bus_d;
    end
  end

  assign dma_rd_req      = (state_q == ISSUE);
  assign dma_rd_addr     = {line_q, {LINE_OFFW{1'b0}}};
  assign common_data_bus = bus_q;
  assign instr_write_en  = (state_q == RESP) && !space_q;
  assign mem_write_en    = (state_q == RESP) && space_q;
  assign busy            = (state_q != IDLE);
  assign dma_err         = err_q;

endmodule
